// File: rtl/thermal_pkg.sv
// thermal_pkg: shared FSM states, frame layout and frame-to-reading conversion
package thermal_pkg;
   localparam int FRAME_BITS = 16;
   localparam logic [7:0] TEMP_FAULT_VALUE = 8'hFF;
   localparam int FAULT_BIT = 2;
   localparam int MSB_BIT = 15;
   localparam int INT_HI = 14;
   localparam int INT_LO = 7;
   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_UPDATE} state_t;
   typedef enum logic {SEL_A, SEL_B} sel_t;
   typedef struct packed {
      logic       fault;
      logic [7:0] temp;
   } reading_t;
   function automatic reading_t convert(input logic [FRAME_BITS-1:0] frame);
      reading_t r;
      r.fault = frame[MSB_BIT] | frame[FAULT_BIT];
      r.temp = r.fault ? TEMP_FAULT_VALUE : frame[INT_HI:INT_LO];
      return r;
   endfunction
endpackage

// File: rtl/thermal_spi_frame.sv
// thermal_spi_frame: one chip-select window (setup, 16 sclk periods, hold) capturing a 16-bit frame
module thermal_spi_frame
   import thermal_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  miso,
   output logic                  cs_n,
   output logic                  sclk,
   output logic [FRAME_BITS-1:0] frame,
   output logic                  done
);
   localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
   state_t                state_q;
   logic [15:0]           cnt_q;
   logic [4:0]            half_q;
   logic                  sclk_q;
   logic                  cs_n_q;
   logic [FRAME_BITS-1:0] shift_q;
   logic                  cnt_last;
   logic                  half_end;
   logic                  rise;
   assign cnt_last = cnt_q == DIV_LAST;
   assign half_end = state_q == S_SHIFT && cnt_last;
   assign rise = half_end && !half_q[0];
   assign done = state_q == S_HOLD && cnt_last;
   assign cs_n = cs_n_q;
   assign sclk = sclk_q;
   assign frame = shift_q;
   // Phase sequencer; CS drops one cycle into SETUP and rises right after HOLD so back-to-back frames leave a both-high cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         half_q  <= '0;
         sclk_q  <= 1'b0;
         cs_n_q  <= 1'b1;
         shift_q <= '0;
      end else begin
         cnt_q  <= (state_q == S_IDLE || cnt_last) ? '0 : cnt_q + 16'd1;
         half_q <= state_q == S_SHIFT ? half_q + {4'd0, cnt_last} : '0;
         sclk_q <= half_end ? !half_q[0] : sclk_q;
         cs_n_q <= !(state_q == S_SETUP || state_q == S_SHIFT || (state_q == S_HOLD && !cnt_last));
         if (rise) shift_q <= {shift_q[FRAME_BITS-2:0], miso};
         case (state_q)
            S_IDLE:  state_q <= start ? S_SETUP : S_IDLE;
            S_SETUP: if (cnt_last) state_q <= S_SHIFT;
            S_SHIFT: if (cnt_last && half_q == 5'd31) state_q <= S_HOLD;
            S_HOLD:  if (cnt_last) state_q <= start ? S_SETUP : S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end
endmodule

// File: rtl/thermal_sensor_reader.sv
// thermal_sensor_reader: polls zone A/B sensors periodically and publishes converted readings as a pair
module thermal_sensor_reader
   import thermal_pkg::*;
#(
   parameter int CLK_DIV       = 4,
   parameter int SAMPLE_PERIOD = 1000
) (
   input  logic       clk,
   input  logic       rst,
   output logic       sclk,
   output logic       cs_a_n,
   output logic       cs_b_n,
   input  logic       miso,
   output logic [7:0] temp_sensor_a,
   output logic [7:0] temp_sensor_b,
   output logic       sensor_fault_a,
   output logic       sensor_fault_b,
   output logic       sample_valid
);
   localparam logic [31:0] PERIOD_LAST = 32'(SAMPLE_PERIOD - 1);
   state_t                state_q;
   sel_t                  sel_q;
   logic [31:0]           cnt_q;
   reading_t              hold_a_q;
   reading_t              hold_b_q;
   reading_t              out_a_q;
   reading_t              out_b_q;
   logic                  valid_q;
   logic                  start;
   logic                  cs_n;
   logic                  done;
   logic [FRAME_BITS-1:0] frame;
   reading_t              reading;
   assign reading = convert(frame);
   assign start = (state_q == S_IDLE && cnt_q == PERIOD_LAST) || (done && sel_q == SEL_A);
   thermal_spi_frame #(.CLK_DIV(CLK_DIV)) u_frame (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .miso  (miso),
      .cs_n  (cs_n),
      .sclk  (sclk),
      .frame (frame),
      .done  (done)
   );
   assign cs_a_n = cs_n | (sel_q != SEL_A);
   assign cs_b_n = cs_n | (sel_q != SEL_B);
   assign temp_sensor_a = out_a_q.temp;
   assign temp_sensor_b = out_b_q.temp;
   assign sensor_fault_a = out_a_q.fault;
   assign sensor_fault_b = out_b_q.fault;
   assign sample_valid = valid_q;
   // Period counter, A-then-B sequencing (S_SETUP covers the whole frame-engine window) and the paired output update
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         sel_q    <= SEL_A;
         cnt_q    <= '0;
         hold_a_q <= '0;
         hold_b_q <= '0;
         out_a_q  <= '0;
         out_b_q  <= '0;
         valid_q  <= 1'b0;
      end else begin
         valid_q <= state_q == S_UPDATE;
         if (done && sel_q == SEL_A) hold_a_q <= reading;
         if (done && sel_q == SEL_B) hold_b_q <= reading;
         if (state_q == S_UPDATE) begin
            out_a_q <= hold_a_q;
            out_b_q <= hold_b_q;
         end
         case (state_q)
            S_IDLE: begin
               cnt_q   <= start ? '0 : cnt_q + 32'd1;
               state_q <= start ? S_SETUP : S_IDLE;
            end
            S_SETUP: begin
               if (done) sel_q <= sel_q == SEL_A ? SEL_B : SEL_A;
               if (done && sel_q == SEL_B) state_q <= S_UPDATE;
            end
            S_UPDATE: state_q <= S_IDLE;
            default:  state_q <= S_IDLE;
         endcase
      end
   end
endmodule

// File: doc/thermal_sensor_reader.md
# thermal_sensor_reader

Serial front end for the thermal subsystem. It periodically polls the zone A and zone B digital temperature sensors over a shared 3-wire SPI-style bus and converts each 16-bit frame to integer °C. It drives the `temp_sensor_a` and `temp_sensor_b` buses consumed by the thermal/Peltier control logic, with per-zone fault flags. Sensor faults force a reading of 8'hFF, so downstream critical-temperature logic fails safe.

## Interface
- `CLK_DIV`, default 4: `clk` cycles per SCLK half-period; must be ≥1.
- `SAMPLE_PERIOD`, default 1000: idle `clk` cycles between conversion pairs; must be ≥1.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `sclk`  out  1  serial clock to both sensors; idles low.
- `cs_a_n`  out  1  zone A chip select, active low.
- `cs_b_n`  out  1  zone B chip select, active low.
- `miso`  in  1  shared serial data from the selected sensor.
- `temp_sensor_a`  out  8  zone A temperature, integer °C.
- `temp_sensor_b`  out  8  zone B temperature, integer °C.
- `sensor_fault_a`  out  1  fault flag for the last zone A frame.
- `sensor_fault_b`  out  1  fault flag for the last zone B frame.
- `sample_valid`  out  1  one-cycle pulse when the temperature pair updates.

## Operation
- FSM states: IDLE → SETUP → SHIFT → HOLD → (next sensor: SETUP | after B: UPDATE) → IDLE. A `sel` register chooses A then B.
- IDLE: count 0..SAMPLE_PERIOD-1, then enter SETUP with `sel`=A. All CS lines are high and `sclk` is low.
- SETUP: the selected CS is low for CLK_DIV cycles with `sclk` low.
- SHIFT: 16 bit periods, each CLK_DIV cycles `sclk` low then CLK_DIV cycles `sclk` high.
  - `miso` is shifted MSB-first into a 16-bit register on the `clk` edge that drives `sclk` high.
- HOLD: CLK_DIV cycles with `sclk` low and CS still low. CS then deasserts. The frame is latched into the per-sensor holding register.
- Frame format:
  - bit15 must be 0.
  - bits14:3 are unsigned temperature in 1/16 °C.
  - bit2 is the open-circuit fault.
  - bits1:0 are ignored.
- Conversion: temperature = frame bits14:7, truncated toward zero with no rounding.
- Fault: bit15 = 1 or bit2 = 1 sets the fault flag and forces the temperature to 8'hFF.
- UPDATE (1 cycle): both temperature outputs and both fault flags are loaded together, `sample_valid` = 1, then the FSM returns to IDLE. Outputs never show a mixed old/new pair.
- Outputs hold their values between UPDATEs.

## Timing
- Reset values: `sclk`=0, `cs_a_n`=1, `cs_b_n`=1, temperatures = 8'h00, fault flags = 0, `sample_valid`=0, FSM in IDLE with count 0.
- `rst` asserted at any point, including mid-frame, takes effect on that edge:
  - all outputs return to reset values on the next cycle;
  - the partial frame is discarded and no `sample_valid` pulse is generated.
- Per-sensor frame length: (2+32)·CLK_DIV cycles. This is 136 cycles at default.
- Cycle count from the first cycle with `rst` low:
  - SETUP A begins at cycle SAMPLE_PERIOD;
  - UPDATE occurs at cycle SAMPLE_PERIOD + 2·34·CLK_DIV, which is cycle 1272 at default;
  - new outputs and `sample_valid` are visible on the following cycle, 1273.
- Steady-state refresh period: SAMPLE_PERIOD + 68·CLK_DIV + 1 cycles.
- `cs_a_n` and `cs_b_n` are never low at the same time. Between the two frames there is at least 1 cycle with both high.
- `sclk`, `cs_*_n`, and `sample_valid` are registered outputs with no combinational paths from `miso`.

## Structure
- Shared package `thermal_pkg` holds:
  - the FSM state enum;
  - `FRAME_BITS`=16;
  - `TEMP_FAULT_VALUE`=8'hFF;
  - the frame field positions: fault bit 2, MSB bit 15, integer field 14:7.
- One sub-module, `thermal_spi_frame`, runs one SETUP/SHIFT/HOLD cycle. Its ports are `start`, `cs_n`, `sclk`, `miso`, 16-bit `frame`, and `done`. The top level owns the period counter, sensor selection, conversion, and output registers.

## Test plan
- Defaults; the sensor model returns A=0x1680 (45.0 °C) and B=0x1E80 (61.0 °C) → at cycle 1273 `temp_sensor_a`=0x2D, `temp_sensor_b`=0x3D, faults 0, `sample_valid` high for exactly 1 cycle.
- A=0x1684 (fault bit2) and B=0x1680 → `temp_sensor_a`=0xFF, `sensor_fault_a`=1, `temp_sensor_b`=0x2D, `sensor_fault_b`=0.
- `miso` stuck at 1 (frame 0xFFFF) for B → `temp_sensor_b`=0xFF, `sensor_fault_b`=1.
- A=0x7FF8 → `temp_sensor_a`=0xFF with `sensor_fault_a`=0. This distinguishes a legitimate maximum from a fault.
- `rst` pulsed during bit 7 of frame A → next cycle `cs_a_n`=1, `sclk`=0, temperatures = 0x00. No `sample_valid` occurs, and the next pulse arrives exactly 1273 cycles after `rst` deasserts.
- CLK_DIV=1 and CLK_DIV=7 → exactly 16 `sclk` rising edges per CS window, high and low widths = CLK_DIV, CS setup and hold = CLK_DIV, CS lines never low at the same time.
